// File: rtl/pir_multicanal.sv
// Multi-channel PIR occupancy detector: per-channel synchroniser, debounce and
// hold-off FSM, plus entry/exit event pulses and room-level occupancy summary.
module pir_multicanal #(
    parameter int N_CANAIS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int HOLD        = 1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_CANAIS-1:0]                pir_in,
    output logic [N_CANAIS-1:0]                ocupado,
    output logic [N_CANAIS-1:0]                evento_entrada,
    output logic [N_CANAIS-1:0]                evento_saida,
    output logic                               algum_ocupado,
    output logic [$clog2(N_CANAIS+1)-1:0]      qtd_ocupados
);

    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(HOLD + 1);
    localparam int QTD_W  = $clog2(N_CANAIS + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    localparam logic [1:0] LIVRE       = 2'd0;
    localparam logic [1:0] CONFIRMANDO = 2'd1;
    localparam logic [1:0] OCUPADO     = 2'd2;
    localparam logic [1:0] SEGURANDO   = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q      [N_CANAIS];
    logic [1:0]             estado      [N_CANAIS];
    logic [1:0]             estado_nx   [N_CANAIS];
    logic [DEB_W-1:0]       cnt_deb     [N_CANAIS];
    logic [DEB_W-1:0]       cnt_deb_nx  [N_CANAIS];
    logic [HOLD_W-1:0]      cnt_hold    [N_CANAIS];
    logic [HOLD_W-1:0]      cnt_hold_nx [N_CANAIS];
    logic [N_CANAIS-1:0]    s;
    logic [N_CANAIS-1:0]    ocupado_nx;

    always_comb begin
        for (int i = 0; i < N_CANAIS; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        for (int i = 0; i < N_CANAIS; i++) begin
            estado_nx[i]   = estado[i];
            cnt_deb_nx[i]  = cnt_deb[i];
            cnt_hold_nx[i] = cnt_hold[i];

            case (estado[i])
                LIVRE: begin
                    if (s[i]) begin
                        if (DEBOUNCE == 1) begin
                            estado_nx[i] = OCUPADO;
                        end else begin
                            estado_nx[i]  = CONFIRMANDO;
                            cnt_deb_nx[i] = DEB_W'(1);
                        end
                    end
                end
                CONFIRMANDO: begin
                    if (!s[i]) begin
                        estado_nx[i]  = LIVRE;
                        cnt_deb_nx[i] = '0;
                    end else if (cnt_deb[i] == DEB_LAST) begin
                        estado_nx[i]  = OCUPADO;
                        cnt_deb_nx[i] = '0;
                    end else begin
                        cnt_deb_nx[i] = cnt_deb[i] + DEB_W'(1);
                    end
                end
                OCUPADO: begin
                    if (!s[i]) begin
                        estado_nx[i]   = SEGURANDO;
                        cnt_hold_nx[i] = '0;
                    end
                end
                SEGURANDO: begin
                    // Any motion during hold-off retriggers without re-debouncing.
                    if (s[i]) begin
                        estado_nx[i]   = OCUPADO;
                        cnt_hold_nx[i] = '0;
                    end else if (cnt_hold[i] == HOLD_LAST) begin
                        estado_nx[i]   = LIVRE;
                        cnt_hold_nx[i] = '0;
                    end else begin
                        cnt_hold_nx[i] = cnt_hold[i] + HOLD_W'(1);
                    end
                end
                default: begin
                    estado_nx[i]   = LIVRE;
                    cnt_deb_nx[i]  = '0;
                    cnt_hold_nx[i] = '0;
                end
            endcase

            ocupado_nx[i] = (estado_nx[i] == OCUPADO) || (estado_nx[i] == SEGURANDO);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-channel arrays are a handful of flops, not a RAM,
            // so clearing them in reset is cheap and makes reset total.
            for (int i = 0; i < N_CANAIS; i++) begin
                sync_q[i]   <= '0;
                estado[i]   <= LIVRE;
                cnt_deb[i]  <= '0;
                cnt_hold[i] <= '0;
            end
            ocupado        <= '0;
            evento_entrada <= '0;
            evento_saida   <= '0;
        end else begin
            for (int i = 0; i < N_CANAIS; i++) begin
                sync_q[i]   <= {sync_q[i][SYNC_STAGES-2:0], pir_in[i]};
                estado[i]   <= estado_nx[i];
                cnt_deb[i]  <= cnt_deb_nx[i];
                cnt_hold[i] <= cnt_hold_nx[i];
            end
            // Events are registered alongside ocupado so they mark the same edge.
            ocupado        <= ocupado_nx;
            evento_entrada <= ocupado_nx & ~ocupado;
            evento_saida   <= ~ocupado_nx & ocupado;
        end
    end

    always_comb begin
        algum_ocupado = |ocupado;
        qtd_ocupados  = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            qtd_ocupados = qtd_ocupados + QTD_W'(ocupado[i]);
        end
    end

endmodule

// File: doc/pir_multicanal.md
# pir_multicanal

Parametrised multi-channel PIR occupancy detector. It is the successor to the single-channel pass-through `pir` block. For each of `N_CANAIS` asynchronous PIR inputs it:
- synchronises the input,
- rejects glitches shorter than `DEBOUNCE` cycles,
- holds occupancy for `HOLD` cycles after motion stops.

It also reports per-zone occupancy, entry/exit event pulses, an any-zone flag and an occupied-zone count to the room controller.

## Interface

Parameters:
- `N_CANAIS`, 4: number of independent PIR channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE`, 4: consecutive synchronised high cycles required to confirm motion (≥1).
- `HOLD`, 1000: cycles occupancy persists after synchronised input goes low (≥1).

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `pir_in`  in  N_CANAIS: raw PIR outputs; asynchronous to `clk`.
- `ocupado`  out  N_CANAIS: registered per-zone occupancy.
- `evento_entrada`  out  N_CANAIS: 1-cycle pulse when `ocupado[i]` goes 0→1.
- `evento_saida`  out  N_CANAIS: 1-cycle pulse when `ocupado[i]` goes 1→0.
- `algum_ocupado`  out  1: OR of `ocupado`.
- `qtd_ocupados`  out  $clog2(N_CANAIS+1): number of set `ocupado` bits.

## Operation

**Channel structure**
- Channels are fully independent and identical.
- `s[i]` is the output of the channel's `SYNC_STAGES`-deep synchroniser.

**Per-channel state machine** (states LIVRE, CONFIRMANDO, OCUPADO, SEGURANDO):
- LIVRE:
  - `s=1`, `DEBOUNCE=1` → OCUPADO.
  - `s=1`, `DEBOUNCE>1` → CONFIRMANDO with `cnt_deb=1`.
  - Otherwise stay.
- CONFIRMANDO:
  - `s=0` → LIVRE, `cnt_deb=0`.
  - `s=1` and `cnt_deb==DEBOUNCE-1` → OCUPADO.
  - Otherwise `cnt_deb+1`.
- OCUPADO:
  - `s=0` → SEGURANDO, `cnt_hold=0`.
  - Otherwise stay.
- SEGURANDO:
  - `s=1` → OCUPADO (retrigger, no re-debounce, hold counter discarded).
  - `s=0` and `cnt_hold==HOLD-1` → LIVRE.
  - Otherwise `cnt_hold+1`.

**Outputs**
- `ocupado[i]` is registered and equals 1 exactly when the state is OCUPADO or SEGURANDO.
- `evento_entrada[i]` and `evento_saida[i]` are registered and update on the same edge as the `ocupado[i]` transition they mark; each lasts exactly one cycle.
- `algum_ocupado` and `qtd_ocupados` are combinational from the `ocupado` register; they add no latency.
- Simultaneous transitions on several channels give simultaneous pulses; `qtd_ocupados` reflects all of them in the same cycle.

**Counter widths**
- `cnt_deb` is $clog2(DEBOUNCE+1) bits; `cnt_hold` is $clog2(HOLD+1) bits.
- Neither counter ever wraps; both are bounded by the compare values above.

**Reset**
- Effective on any edge with `rst=1`, including mid-debounce or mid-hold.
- Clears synchroniser flops, states (LIVRE), counters, `ocupado`, and both event vectors to 0.
- `evento_saida` is not pulsed when reset clears an occupied channel.
- All outputs read 0 from the first edge with `rst=1` until a channel re-confirms.

## Timing

**Edge numbering:** edge 1 is the first rising edge at which `pir_in[i]=1` (or `=0`, for release) is sampled with `rst=0`.

**Rise**
- `ocupado[i]` and `evento_entrada[i]` are high after edge `SYNC_STAGES+DEBOUNCE`.
- Defaults: edge 6.

**Glitch rejection**
- A high pulse spanning fewer than `DEBOUNCE` sampling edges never asserts `ocupado`.

**Fall**
- Release is sampled at edge 1; `SEGURANDO` is entered at edge `SYNC_STAGES+1`.
- `ocupado[i]` clears and `evento_saida[i]` pulses after edge `SYNC_STAGES+1+HOLD`, provided no retrigger occurs.

**Retrigger**
- Any synchronised high cycle during SEGURANDO returns the channel to OCUPADO.
- The next release restarts the full `HOLD` count.

**Release during reset**
- If `rst` falls while `pir_in` is high, the rise latency counts from the first edge with `rst=0`.

## Test plan

Bench configuration: `N_CANAIS=4`, `SYNC_STAGES=2`, `DEBOUNCE=4`, `HOLD=8`.

1. **Reset:** `rst=1` for 3 cycles with `pir_in=4'hF`.
   - During reset: `ocupado=0`, `qtd_ocupados=0`, no events.
   - After release: `ocupado=4'hF` after edge 6; `qtd_ocupados=4`; `evento_entrada=4'hF` for 1 cycle.
2. **Glitch:** `pir_in[0]` high for 3 cycles, then low.
   - `ocupado[0]` stays 0; no event pulses.
3. **Clean occupancy:** `pir_in[1]` high for 10 cycles, then low.
   - `ocupado[1]` and a 1-cycle `evento_entrada[1]` after edge 6 of the rise.
   - `ocupado[1]` clears with a 1-cycle `evento_saida[1]` after edge 11 of the fall.
4. **Retrigger:** after confirming channel 2, drive low for 5 cycles, high for 1 cycle, then low.
   - `ocupado[2]` stays 1 throughout; no `evento_saida[2]` at the first release.
   - Clears after edge 11 counted from the second fall.
5. **Multi-channel:** rises on channels 0 and 3 in the same cycle, then channel 2 later.
   - Both `evento_entrada` bits pulse together; `qtd_ocupados` goes 0→2→3; `algum_ocupado=1`.
6. **Reset mid-hold:** assert `rst` for 1 cycle while channel 1 is in SEGURANDO.
   - `ocupado[1]=0` from that edge; `evento_saida[1]` stays 0.
   - Channel stays LIVRE while input is low.
